// File: rtl/fc_pkg.sv
// Shared definitions for the fringe rate counter: crossing FSM encoding and FC_mode values.
package fc_pkg;

  typedef enum logic [1:0] {
    FC_IDLE = 2'b00,
    FC_LOW  = 2'b01,
    FC_HIGH = 2'b10
  } fc_state_e;

  localparam logic FC_MODE_FALL = 1'b0;
  localparam logic FC_MODE_BOTH = 1'b1;

endpackage

// File: rtl/fc_crossing_detector.sv
// Hysteresis threshold FSM; emits same-cycle rise/fall strobes on accepted samples.
module fc_crossing_detector
  import fc_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  clr_i,
  input  logic                  vld_i,
  input  logic [DATA_WIDTH-1:0] sample_i,
  input  logic [DATA_WIDTH-1:0] upper_i,
  input  logic [DATA_WIDTH-1:0] lower_i,
  output logic                  rise_o,
  output logic                  fall_o
);

  fc_state_e state_q, state_d;
  logic      above, below;

  assign above = $signed(sample_i) > $signed(upper_i);
  assign below = $signed(sample_i) < $signed(lower_i);

  always_comb begin
    state_d = state_q;
    rise_o  = 1'b0;
    fall_o  = 1'b0;
    if (vld_i) begin
      case (state_q)
        FC_IDLE: begin
          if (below)      state_d = FC_LOW;
          else if (above) state_d = FC_HIGH;
        end
        FC_LOW: begin
          if (above) begin
            state_d = FC_HIGH;
            rise_o  = 1'b1;
          end
        end
        FC_HIGH: begin
          if (below) begin
            state_d = FC_LOW;
            fall_o  = 1'b1;
          end
        end
        default: state_d = FC_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) state_q <= FC_IDLE;
    else                state_q <= state_d;
  end

endmodule

// File: rtl/fringe_rate_counter.sv
// Fringe position counter with gated event-rate output. Optional macro FC_HOLDOFF_EN
// suppresses events that follow a counted event too closely.
module fringe_rate_counter
  import fc_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int COUNT_WIDTH    = 32,
  parameter int GATE_WIDTH     = 32,
  parameter int HOLDOFF_CYCLES = 4
) (
  input  logic                   SYS_aclk,
  input  logic                   SYS_reset,
  input  logic                   FC_sign,
  input  logic                   FC_mode,
  input  logic                   FC_clear,
  input  logic [DATA_WIDTH-1:0]  FC_upper_threshold,
  input  logic [DATA_WIDTH-1:0]  FC_lower_threshold,
  input  logic [GATE_WIDTH-1:0]  FC_gate_period,
  input  logic                   S_AXIS_tvalid,
  input  logic [DATA_WIDTH-1:0]  S_AXIS_tdata,
  output logic                   S_AXIS_tready,
  output logic                   M_AXIS_tvalid,
  output logic [COUNT_WIDTH-1:0] M_AXIS_tdata,
  output logic                   M_AXIS_RATE_tvalid,
  output logic [GATE_WIDTH-1:0]  M_AXIS_RATE_tdata,
  input  logic                   M_AXIS_RATE_tready,
  output logic                   FC_rate_overrun
);

  localparam logic [GATE_WIDTH-1:0]  G_ONE = GATE_WIDTH'(1);
  localparam logic [COUNT_WIDTH-1:0] C_ONE = COUNT_WIDTH'(1);

  function automatic logic [GATE_WIDTH-1:0] sat_inc(input logic [GATE_WIDTH-1:0] v,
                                                    input logic inc);
    if (inc && (v != '1)) return v + G_ONE;
    return v;
  endfunction

  logic rise, fall, ev_raw, ev;

  fc_crossing_detector #(.DATA_WIDTH(DATA_WIDTH)) u_det (
    .clk_i    (SYS_aclk),
    .rst_i    (SYS_reset),
    .clr_i    (FC_clear),
    .vld_i    (S_AXIS_tvalid),
    .sample_i (S_AXIS_tdata),
    .upper_i  (FC_upper_threshold),
    .lower_i  (FC_lower_threshold),
    .rise_o   (rise),
    .fall_o   (fall)
  );

  assign ev_raw = fall | (rise & (FC_mode == FC_MODE_BOTH));

`ifdef FC_HOLDOFF_EN
  localparam int HW = $clog2(HOLDOFF_CYCLES + 2);
  logic [HW-1:0] hold_q, hold_d;

  assign ev = ev_raw && (hold_q == '0);

  // Holdoff counts down on accepted samples only, so idle cycles do not shorten it.
  always_comb begin
    hold_d = hold_q;
    if (ev)                                  hold_d = HW'(HOLDOFF_CYCLES);
    else if (S_AXIS_tvalid && hold_q != '0)  hold_d = hold_q - HW'(1);
  end

  always_ff @(posedge SYS_aclk) begin
    if (SYS_reset || FC_clear) hold_q <= '0;
    else                       hold_q <= hold_d;
  end
`else
  logic unused_holdoff;
  assign unused_holdoff = (HOLDOFF_CYCLES != 0);
  assign ev = ev_raw;
`endif

  logic [COUNT_WIDTH-1:0] pos_q, pos_d;
  logic [GATE_WIDTH-1:0]  period_q, period_d, gate_q, gate_d, evt_q, evt_d, rate_q, rate_d;
  logic                   rate_vld_q, rate_vld_d, ovr_q, ovr_d, win_end;

  assign win_end = (period_q != '0) && (gate_q == period_q - G_ONE);

  always_comb begin
    pos_d      = pos_q;
    period_d   = period_q;
    gate_d     = gate_q;
    evt_d      = evt_q;
    rate_d     = rate_q;
    ovr_d      = ovr_q;
    rate_vld_d = rate_vld_q & ~M_AXIS_RATE_tready;
    if (ev) pos_d = FC_sign ? pos_q + C_ONE : pos_q - C_ONE;
    // A zero period idles the gate and keeps re-sampling the period input.
    if (period_q == '0) begin
      gate_d   = '0;
      evt_d    = '0;
      period_d = FC_gate_period;
    end else if (win_end) begin
      gate_d     = '0;
      evt_d      = '0;
      period_d   = FC_gate_period;
      rate_d     = sat_inc(evt_q, ev);
      rate_vld_d = 1'b1;
      if (rate_vld_q && !M_AXIS_RATE_tready) ovr_d = 1'b1;
    end else begin
      gate_d = gate_q + G_ONE;
      evt_d  = sat_inc(evt_q, ev);
    end
  end

  always_ff @(posedge SYS_aclk) begin
    if (SYS_reset) begin
      pos_q      <= '0;
      period_q   <= FC_gate_period;
      gate_q     <= '0;
      evt_q      <= '0;
      rate_q     <= '0;
      rate_vld_q <= 1'b0;
      ovr_q      <= 1'b0;
    end else if (FC_clear) begin
      pos_q      <= '0;
      period_q   <= FC_gate_period;
      gate_q     <= '0;
      evt_q      <= '0;
      rate_vld_q <= 1'b0;
      ovr_q      <= 1'b0;
    end else begin
      pos_q      <= pos_d;
      period_q   <= period_d;
      gate_q     <= gate_d;
      evt_q      <= evt_d;
      rate_q     <= rate_d;
      rate_vld_q <= rate_vld_d;
      ovr_q      <= ovr_d;
    end
  end

  assign S_AXIS_tready      = 1'b1;
  assign M_AXIS_tvalid      = 1'b1;
  assign M_AXIS_tdata       = pos_q;
  assign M_AXIS_RATE_tvalid = rate_vld_q;
  assign M_AXIS_RATE_tdata  = rate_q;
  assign FC_rate_overrun    = ovr_q;

endmodule

// File: tb/tb_fringe_rate_counter.sv
// Directed bench for fringe_rate_counter: vector table for position, sequences for gate/rate.
module tb_fringe_rate_counter;

  logic        clk = 1'b0;
  logic        rst, sign, mode, clr, s_vld, rate_rdy;
  logic [31:0] upper, lower, gate_per, s_data;
  logic        s_rdy, m_vld, r_vld, ovr;
  logic [31:0] m_data, r_data;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fringe_rate_counter dut (
    .SYS_aclk           (clk),
    .SYS_reset          (rst),
    .FC_sign            (sign),
    .FC_mode            (mode),
    .FC_clear           (clr),
    .FC_upper_threshold (upper),
    .FC_lower_threshold (lower),
    .FC_gate_period     (gate_per),
    .S_AXIS_tvalid      (s_vld),
    .S_AXIS_tdata       (s_data),
    .S_AXIS_tready      (s_rdy),
    .M_AXIS_tvalid      (m_vld),
    .M_AXIS_tdata       (m_data),
    .M_AXIS_RATE_tvalid (r_vld),
    .M_AXIS_RATE_tdata  (r_data),
    .M_AXIS_RATE_tready (rate_rdy),
    .FC_rate_overrun    (ovr)
  );

  typedef struct {
    logic        clr;
    logic        mode;
    logic        sign;
    logic        vld;
    logic [31:0] data;
    logic [31:0] exp_pos;
  } vec_t;

  vec_t vt[$];

  function automatic void add(input logic c, input logic m, input logic s, input logic v,
                              input logic signed [31:0] d, input logic [31:0] e);
    vec_t r;
    r.clr = c; r.mode = m; r.sign = s; r.vld = v; r.data = d; r.exp_pos = e;
    vt.push_back(r);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are sampled at the same point.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic signed [31:0] d);
    s_vld  = v;
    s_data = d;
    tick();
  endtask

  int signed seq_a[10] = '{-200, 200, -200, 200, -200, 200, -200, 0, 0, 0};
  int signed seq_b[8]  = '{-200, 200, -200, 0, 200, -200, 200, -200};
  logic [31:0] hold_exp;

  initial begin
    rst = 1'b1; sign = 1'b1; mode = 1'b0; clr = 1'b0; s_vld = 1'b0; s_data = '0;
    rate_rdy = 1'b1; upper = 32'd100; lower = -32'sd100; gate_per = '0;

    // position vectors: clr, mode, sign, vld, data, expected position
    add(0,0,1,1,0,0); add(0,0,1,1,-200,0); add(0,0,1,1,200,0);
    add(0,0,1,1,-200,1); add(0,0,1,1,200,1); add(0,0,1,1,-200,2);
    add(1,0,1,0,0,0);
    add(0,1,1,1,0,0); add(0,1,1,1,-200,0); add(0,1,1,1,200,1);
    add(0,1,1,1,-200,2); add(0,1,1,1,200,3); add(0,1,1,1,-200,4);
    add(1,0,1,0,0,0);
    add(0,0,0,1,0,0); add(0,0,0,1,-200,0); add(0,0,0,1,200,0);
    add(0,0,0,1,-200,32'hFFFF_FFFF); add(0,0,0,1,200,32'hFFFF_FFFF);
    add(0,0,0,1,-200,32'hFFFF_FFFE);
    add(1,1,1,0,0,0);
    add(0,1,1,1,-200,0); add(0,1,1,1,100,0); add(0,1,1,1,101,1);
    add(0,1,1,1,-100,1); add(0,1,1,1,-101,2); add(0,1,1,0,200,2); add(0,1,1,1,200,3);
    add(1,1,1,1,-200,0); add(0,1,1,1,200,0); add(0,1,1,1,-200,1);

    tick(); tick();
    check("reset_pos", m_data, 32'd0);
    check("reset_rate_vld", {31'd0, r_vld}, 32'd0);
    check("reset_rate_data", r_data, 32'd0);
    check("reset_overrun", {31'd0, ovr}, 32'd0);
    check("reset_tready", {31'd0, s_rdy}, 32'd1);
    check("reset_m_tvalid", {31'd0, m_vld}, 32'd1);
    rst = 1'b0;

    foreach (vt[i]) begin
      clr = vt[i].clr; mode = vt[i].mode; sign = vt[i].sign;
      drive(vt[i].vld, vt[i].data);
      check($sformatf("vec%0d_pos", i), m_data, vt[i].exp_pos);
    end
    check("gate0_no_rate", {31'd0, r_vld}, 32'd0);

    // Gate period 10: three falling events, rate appears after the tenth window cycle.
    mode = 1'b0; sign = 1'b1; gate_per = 32'd10; clr = 1'b1;
    drive(1'b0, 0);
    clr = 1'b0;
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, seq_a[i]);
      if (i == 8) check("win10_early_vld", {31'd0, r_vld}, 32'd0);
    end
    check("win10_vld", {31'd0, r_vld}, 32'd1);
    check("win10_rate", r_data, 32'd3);
    drive(1'b1, 0);
    check("win10_vld_drop", {31'd0, r_vld}, 32'd0);
    for (int i = 0; i < 9; i++) drive(1'b1, 0);
    check("win10_second_vld", {31'd0, r_vld}, 32'd1);
    check("win10_second_rate", r_data, 32'd0);

    // Gate period 4 with tready low across two windows.
    gate_per = 32'd4; clr = 1'b1; rate_rdy = 1'b0;
    drive(1'b0, 0);
    clr = 1'b0;
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, seq_b[i]);
      if (i == 3) begin
        check("win4_first_rate", r_data, 32'd1);
        check("win4_first_ovr", {31'd0, ovr}, 32'd0);
        hold_exp = r_data;
      end
      if (i == 5) check("win4_hold_rate", r_data, 32'd1);
    end
    check("win4_vld", {31'd0, r_vld}, 32'd1);
    check("win4_second_rate", r_data, 32'd2);
    check("win4_overrun", {31'd0, ovr}, 32'd1);
    clr = 1'b1;
    drive(1'b0, 0);
    clr = 1'b0;
    check("clear_overrun", {31'd0, ovr}, 32'd0);
    check("clear_rate_vld", {31'd0, r_vld}, 32'd0);
    rate_rdy = 1'b1;

    // Two falling events two samples apart.
    gate_per = '0; clr = 1'b1;
    drive(1'b0, 0);
    clr = 1'b0;
    drive(1'b1, -200); drive(1'b1, 200); drive(1'b1, -200); drive(1'b1, 200); drive(1'b1, -200);
`ifdef FC_HOLDOFF_EN
    check("holdoff_pos", m_data, 32'd1);
`else
    check("holdoff_pos", m_data, 32'd2);
`endif

    // Reset in the middle of a window discards it.
    gate_per = 32'd4; clr = 1'b1;
    drive(1'b0, 0);
    clr = 1'b0;
    drive(1'b1, -200); drive(1'b1, 200);
    rst = 1'b1;
    drive(1'b1, -200);
    rst = 1'b0;
    check("midrst_pos", m_data, 32'd0);
    check("midrst_vld", {31'd0, r_vld}, 32'd0);
    check("midrst_rate", r_data, 32'd0);
    drive(1'b0, 0); drive(1'b0, 0);
    check("midrst_vld_later", {31'd0, r_vld}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
